// File: rtl/fourbit_divider_if.sv
// fourbit_divider_if: start/done handshake, operands and results of the restoring divider
interface fourbit_divider_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/fourbit_divider.sv
// fourbit_divider: sequential unsigned restoring divider, one subtract/restore step per clock
module fourbit_divider #(parameter int WIDTH = 4) (
  input  logic clk,
  input  logic rst_n,
  fourbit_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, next;
  logic [WIDTH:0] r, sh, t;
  logic [WIDTH-1:0] q, dvs, dvd, quo, rem;
  logic [CW-1:0] cnt;
  logic zero, done, dbz;
  // {R,Q} shifted left; subtract as R + ~{0,divisor} + 1, borrow shows in the MSB
  assign sh = {r[WIDTH-1:0], q[WIDTH-1]};
  assign t  = sh + ~{1'b0, dvs} + ONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (bus.start) next = (bus.divisor == '0) ? FIN : RUN;
      RUN:     if (cnt == CW'(1)) next = FIN;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r    <= '0;
      q    <= '0;
      dvs  <= '0;
      dvd  <= '0;
      cnt  <= '0;
      zero <= 1'b0;
      done <= 1'b0;
      quo  <= '0;
      rem  <= '0;
      dbz  <= 1'b0;
    end else begin
      done <= state == FIN;
      if (state == IDLE && bus.start) begin
        dvd  <= bus.dividend;
        dvs  <= bus.divisor;
        r    <= '0;
        q    <= bus.dividend;
        cnt  <= CW'(WIDTH);
        zero <= bus.divisor == '0;
      end
      if (state == RUN) begin
        r   <= t[WIDTH] ? sh : t;
        q   <= {q[WIDTH-2:0], ~t[WIDTH]};
        cnt <= cnt - CW'(1);
      end
      if (state == FIN) begin
        quo <= zero ? '1 : q;
        rem <= zero ? dvd : r[WIDTH-1:0];
        dbz <= zero;
      end
    end
  assign bus.busy        = state != IDLE;
  assign bus.done        = done;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_fourbit_divider.sv
// tb_fourbit_divider: directed vector table, handshake corner cases and exhaustive sweep
module tb_fourbit_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  fourbit_divider_if #(.WIDTH(4)) bus ();
  fourbit_divider #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                         input logic [3:0] er, input logic ez, input string nm);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, " busy_after_start"}, int'(bus.busy), 1);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, ez ? 1 : 5);
    chk({nm, " quotient"}, int'(bus.quotient), int'(eq));
    chk({nm, " remainder"}, int'(bus.remainder), int'(er));
    chk({nm, " div_by_zero"}, int'(bus.div_by_zero), int'(ez));
    chk({nm, " busy_at_done"}, int'(bus.busy), 0);
    @(negedge clk);
    chk({nm, " done_pulse_width"}, int'(bus.done), 0);
  endtask
  initial begin
    int lat;
    int seen;
    vecs[0] = '{4'd13, 4'd3, 4'd4, 4'd1, 1'b0};
    vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
    vecs[2] = '{4'd5, 4'd7, 4'd0, 4'd5, 1'b0};
    vecs[3] = '{4'd0, 4'd9, 4'd0, 4'd0, 1'b0};
    vecs[4] = '{4'd9, 4'd0, 4'd15, 4'd9, 1'b1};
    vecs[5] = '{4'd8, 4'd2, 4'd4, 4'd0, 1'b0};
    vecs[6] = '{4'd14, 4'd4, 4'd3, 4'd2, 1'b0};
    vecs[7] = '{4'd7, 4'd7, 4'd1, 4'd0, 1'b0};
    vecs[8] = '{4'd0, 4'd0, 4'd15, 4'd0, 1'b1};
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset quotient", int'(bus.quotient), 0);
    chk("reset remainder", int'(bus.remainder), 0);
    chk("reset div_by_zero", int'(bus.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++)
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, $sformatf("vec%0d", i));
    // start pulsed with new operands mid-division must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 4'd2;
    bus.divisor = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 2;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_ignore latency", lat, 5);
    chk("busy_ignore quotient", int'(bus.quotient), 4);
    chk("busy_ignore remainder", int'(bus.remainder), 1);
    // start raised on the done cycle starts the next division at once
    bus.start = 1'b1;
    bus.dividend = 4'd11;
    bus.divisor = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b busy", int'(bus.busy), 1);
    chk("b2b held quotient", int'(bus.quotient), 4);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b latency", lat, 5);
    chk("b2b quotient", int'(bus.quotient), 5);
    chk("b2b remainder", int'(bus.remainder), 1);
    // asynchronous reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", int'(bus.busy), 0);
    chk("midreset quotient", int'(bus.quotient), 0);
    chk("midreset remainder", int'(bus.remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("midreset no_done", seen, 0);
    run_div(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, "after_reset");
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_div(4'(a), 4'(b), b == 0 ? 4'hf : 4'(a / b), b == 0 ? 4'(a) : 4'(a % b),
                b == 0, $sformatf("ex%0d/%0d", a, b));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
